gamma_replay_demux: RTL and testbench

Parametrised replay demultiplexer for the time-multiplexed macro column. The shared column processes one network per gamma cycle in round-robin order. This block captures the column's muxed output spikes into a per-network ping-pong frame store. It then replays every network's most recently completed frame, slot-aligned, on dedicated per-network outputs in every gamma cycle. It generalises the two-network demux to N_NET networks, adds frame bookkeeping and validity, and adds optional frame-length checking.

---
 rtl/gamma_replay_demux.sv | 176 +++++++++++++++++
 tb/tb_gamma_replay_demux.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/gamma_replay_demux.sv
// gamma_replay_demux: captures the shared column's time-multiplexed output
// spikes into a per-network ping-pong frame store. Every gamma cycle it replays
// each network's last committed frame, slot-aligned, on its own output lane.
//
// Ports:
//   clk                    sole clock, all state on rising edge
//   rstb                   asynchronous active-low reset
//   grst                   gamma-cycle start strobe (marks slot 0)
//   muxed_output_spikes    column output for the active network, current slot
//   demuxed_output_spikes  replayed spikes, lane n at [n*Q +: Q], registered
//   net_valid              lane n holds a committed frame
//   active_net             network currently being captured
//   frame_err              one-cycle pulse on a frame-length violation
//
// Optional feature: define REPLAY_FRAME_CHECK_EN to detect overlong frames.
// An overlong frame enters OVERRUN and is discarded at the next grst. Without
// the macro, the slot counter wraps and capture overwrites from slot 0.
module gamma_replay_demux #(
  parameter int unsigned Q                  = 2,
  parameter int unsigned N_NET              = 2,
  parameter int unsigned GAMMA_CYCLE_LENGTH = 18
) (
  input  logic                      clk,
  input  logic                      rstb,
  input  logic                      grst,
  input  logic [Q-1:0]              muxed_output_spikes,
  output logic [N_NET*Q-1:0]        demuxed_output_spikes,
  output logic [N_NET-1:0]          net_valid,
  output logic [$clog2(N_NET)-1:0]  active_net,
  output logic                      frame_err
);

  localparam int unsigned L  = GAMMA_CYCLE_LENGTH;
  localparam int unsigned NW = $clog2(N_NET);
  localparam int unsigned SW = $clog2(L);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1
`ifdef REPLAY_FRAME_CHECK_EN
    ,
    OVERRUN = 2'd2
`endif
  } state_t;

  state_t          state, state_d;
  logic [SW-1:0]   slot, slot_d;
  logic [NW-1:0]   net_d, next_net_c;
  logic            commit_c, open_c, wr_c;
  logic [N_NET*Q-1:0] demux_d;
  logic [N_NET-1:0]   rd_bank;
  logic [Q-1:0]    mem [N_NET][2][L];
`ifdef REPLAY_FRAME_CHECK_EN
  logic            err_c;
`endif

  // Round-robin successor of the active network.
  assign next_net_c = (active_net == NW'(N_NET - 1)) ? '0 : active_net + NW'(1);

  // State register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state <= IDLE;
    else       state <= state_d;
  end

  // Next state, capture control and replay lane selection.
  // slot_d is the slot of the current cycle (0 on grst).
  always_comb begin
    logic rb;
    logic vb;
    state_d  = state;
    slot_d   = slot;
    net_d    = active_net;
    commit_c = 1'b0;
    open_c   = 1'b0;
    wr_c     = 1'b0;
    demux_d  = '0;
    rb       = 1'b0;
    vb       = 1'b0;
`ifdef REPLAY_FRAME_CHECK_EN
    err_c    = 1'b0;
`endif
    case (state)
      IDLE: begin
        slot_d = '0;
        if (grst) begin
          state_d = RUN;
          open_c  = 1'b1;
          wr_c    = 1'b1;
          net_d   = '0;
        end
      end
      RUN: begin
        if (grst) begin
          commit_c = 1'b1;
          open_c   = 1'b1;
          wr_c     = 1'b1;
          slot_d   = '0;
          net_d    = next_net_c;
        end else if (slot == SW'(L - 1)) begin
`ifdef REPLAY_FRAME_CHECK_EN
          state_d = OVERRUN;
          err_c   = 1'b1;
`else
          wr_c   = 1'b1;
          slot_d = '0;
`endif
        end else begin
          wr_c   = 1'b1;
          slot_d = slot + SW'(1);
        end
      end
`ifdef REPLAY_FRAME_CHECK_EN
      OVERRUN: begin
        // The overlong frame is dropped: open the next one without a commit.
        if (grst) begin
          state_d = RUN;
          open_c  = 1'b1;
          wr_c    = 1'b1;
          slot_d  = '0;
          net_d   = next_net_c;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // Replay reads the post-commit view so a new frame starts at slot 0
    // of the gamma cycle right after its capture.
    for (int n = 0; n < N_NET; n++) begin
      rb = rd_bank[n] ^ (commit_c && (active_net == NW'(n)));
      vb = net_valid[n] | (commit_c && (active_net == NW'(n)));
      if (state_d == RUN && vb) demux_d[n*Q +: Q] = mem[n][rb][slot_d];
    end
  end

  // Frame store, bank bookkeeping and registered outputs.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      slot                  <= '0;
      active_net            <= '0;
      rd_bank               <= '0;
      net_valid             <= '0;
      demuxed_output_spikes <= '0;
      for (int n = 0; n < N_NET; n++)
        for (int b = 0; b < 2; b++)
          for (int s = 0; s < L; s++)
            mem[n][b][s] <= '0;
    end else begin
      slot                  <= slot_d;
      active_net            <= net_d;
      demuxed_output_spikes <= demux_d;
      if (commit_c) begin
        rd_bank[active_net]   <= ~rd_bank[active_net];
        net_valid[active_net] <= 1'b1;
      end
      // Clear the new capture bank; the slot-0 write below overrides it.
      if (open_c)
        for (int s = 0; s < L; s++)
          mem[net_d][~rd_bank[net_d]][s] <= '0;
      if (wr_c)
        mem[net_d][~rd_bank[net_d]][slot_d] <= muxed_output_spikes;
    end
  end

`ifdef REPLAY_FRAME_CHECK_EN
  // Frame-length violation pulse.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) frame_err <= 1'b0;
    else       frame_err <= err_c;
  end
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_gamma_replay_demux.sv
module tb_gamma_replay_demux;

  localparam int unsigned Q = 2;
  localparam int unsigned N = 3;
  localparam int unsigned L = 4;

  typedef struct packed {
    logic [N*Q-1:0] lanes;
    logic [N-1:0]   valid;
    logic [1:0]     net;
    logic           err;
  } exp_t;

  logic           clk = 1'b0;
  logic           rstb;
  logic           grst;
  logic [Q-1:0]   spk;
  logic [N*Q-1:0] dmx;
  logic [N-1:0]   nv;
  logic [1:0]     an;
  logic           fe;

  int total = 0;
  int bad   = 0;
  int mon_cyc = 0;

  exp_t exp_q[$];
  exp_t me;

  // Reference model: whole frames copied on commit.
  bit           m_run, m_ovr;
  int           m_net, m_slot;
  logic [Q-1:0] m_cap [L];
  logic [Q-1:0] m_frm [N][L];
  bit           m_val [N];

  gamma_replay_demux #(.Q(Q), .N_NET(N), .GAMMA_CYCLE_LENGTH(L)) dut (
    .clk                  (clk),
    .rstb                 (rstb),
    .grst                 (grst),
    .muxed_output_spikes  (spk),
    .demuxed_output_spikes(dmx),
    .net_valid            (nv),
    .active_net           (an),
    .frame_err            (fe)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_ovr = 0; m_net = 0; m_slot = 0;
    for (int i = 0; i < L; i++) m_cap[i] = '0;
    for (int n = 0; n < N; n++) begin
      m_val[n] = 0;
      for (int i = 0; i < L; i++) m_frm[n][i] = '0;
    end
  endtask

  task automatic open_frame(input logic [Q-1:0] s);
    m_slot = 0;
    for (int i = 0; i < L; i++) m_cap[i] = '0;
    m_cap[0] = s;
  endtask

  // Outputs expected after the clock edge that consumes (g, s).
  task automatic model_step(input logic g, input logic [Q-1:0] s, output exp_t e);
    bit err;
    err = 0;
    if (!m_run) begin
      if (g) begin
        m_run = 1; m_ovr = 0; m_net = 0;
        open_frame(s);
      end
    end else if (g) begin
      if (!m_ovr) begin
        for (int i = 0; i < L; i++) m_frm[m_net][i] = m_cap[i];
        m_val[m_net] = 1;
      end
      m_ovr = 0;
      m_net = (m_net + 1) % N;
      open_frame(s);
    end else if (!m_ovr) begin
      m_slot++;
      if (m_slot == L) begin
`ifdef REPLAY_FRAME_CHECK_EN
        m_ovr = 1;
        err   = 1;
`else
        m_slot = 0;
`endif
      end
      if (!m_ovr) m_cap[m_slot] = s;
    end
    e = '0;
    for (int n = 0; n < N; n++) begin
      e.valid[n] = m_val[n];
      if (m_run && !m_ovr && m_val[n]) e.lanes[n*Q +: Q] = m_frm[n][m_slot];
    end
    e.net = 2'(m_net);
    e.err = err;
  endtask

  task automatic cyc(input logic g, input logic [Q-1:0] s);
    exp_t e;
    grst = g;
    spk  = s;
    model_step(g, s, e);
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without a clock edge.
  task automatic async_reset();
    #5;
    grst = 1'b0;
    rstb = 1'b0;
    #1;
    check("async_reset", 32'({dmx, nv, an, fe}), 32'd0);
    model_reset();
    #2;
    rstb = 1'b1;
  endtask

  // Monitor: pops one expectation per consumed edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      me = exp_q.pop_front();
      mon_cyc++;
      check($sformatf("cycle%0d", mon_cyc), 32'({dmx, nv, an, fe}), 32'(me));
    end
  end

  initial begin
    rstb = 1'b0;
    grst = 1'b0;
    spk  = '0;
    model_reset();
    #12;
    check("reset_state", 32'({dmx, nv, an, fe}), 32'd0);
    @(negedge clk);
    rstb = 1'b1;
    @(posedge clk);
    #1;

    // Single frame for net0, then commit.
    cyc(1'b1, 2'b01); cyc(1'b0, 2'b10); cyc(1'b0, 2'b11); cyc(1'b0, 2'b00);
    cyc(1'b1, 2'b01);
    check("nv_after_first", 32'(nv), 32'(3'b001));
    check("lane0_slot0", 32'(dmx[1:0]), 32'(2'b01));
    // Constant frames net1=01, net2=10, net0=11.
    for (int i = 0; i < 3; i++) cyc(1'b0, 2'b01);
    cyc(1'b1, 2'b10);
    for (int i = 0; i < 3; i++) cyc(1'b0, 2'b10);
    cyc(1'b1, 2'b11);
    check("nv_all", 32'(nv), 32'(3'b111));
    check("active_wrap", 32'(an), 32'd0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 2'b11);
    // Short frame for net1: 11,11 then grst.
    cyc(1'b1, 2'b11); cyc(1'b0, 2'b11);
    cyc(1'b1, 2'b00);
    for (int i = 0; i < 3; i++) cyc(1'b0, 2'($urandom_range(0, 3)));
    // Withheld grst: overrun or wrap depending on build.
    cyc(1'b1, 2'b10);
    for (int i = 0; i < 6; i++) cyc(1'b0, 2'($urandom_range(0, 3)));
    cyc(1'b1, 2'b01);
    for (int i = 0; i < 4; i++) cyc(1'b0, 2'($urandom_range(0, 3)));

    // Reset mid-frame at slot 2.
    cyc(1'b1, 2'b11); cyc(1'b0, 2'b10); cyc(1'b0, 2'b01);
    async_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) cyc(1'b0, 2'($urandom_range(0, 3)));
    check("idle_active", 32'(an), 32'd0);

    // Back-to-back grst: 1-slot frames.
    cyc(1'b1, 2'b01); cyc(1'b1, 2'b10); cyc(1'b1, 2'b11); cyc(1'b1, 2'b01);
    for (int i = 0; i < 5; i++) cyc(1'b0, 2'($urandom_range(0, 3)));

    // Randomized traffic with variable frame lengths.
    for (int i = 0; i < 400; i++)
      cyc(logic'($urandom_range(0, 4) == 0), 2'($urandom_range(0, 3)));

    grst = 1'b0;
    repeat (2) @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
